fpu_addsub: RTL and testbench

FPU_ADDSUB -- requirements
Module: fpu_addsub

---
 rtl/fpu_addsub_pkg.sv | 43 ++++
 rtl/fpu_addsub_lzc12.sv | 16 +
 rtl/fpu_addsub.sv | 130 +++++++++++++
 tb/tb_fpu_addsub.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_addsub_pkg.sv
// Shared float-format definitions for the processor's 16-bit float datapath.
// Field positions, exponent limits and add/sub opcodes used by every FPU path.
package fpu_addsub_pkg;

    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 7;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 7;
    localparam int MAN_W    = FRAC_W + 1;   // hidden one + fraction
    localparam int GRD_W    = 3;            // extra low bits kept through alignment
    localparam int ALN_W    = MAN_W + GRD_W;
    localparam int SUM_W    = ALN_W + 1;    // room for the carry out of the add

    localparam logic [EXP_W-1:0] BIAS    = 8'd127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'd254;
    localparam logic [14:0]      SAT_MAG = 15'h7F7F;

    typedef enum logic {
        OPaddf = 1'b0,
        OPsubf = 1'b1
    } fpu_op_e;

    // Mantissa with hidden one; an exponent of zero means the operand is zero.
    function automatic logic [MAN_W-1:0] fp_mant(input logic [EXP_MSB:0] mag);
        return (mag[EXP_MSB:EXP_LSB] == '0) ? '0 : {1'b1, mag[FRAC_W-1:0]};
    endfunction

    typedef struct packed {
        logic             sign_l;
        logic             sign_s;
        logic [EXP_W-1:0] exp;
        logic [ALN_W-1:0] man_l;
        logic [ALN_W-1:0] man_s;
    } align_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SUM_W-1:0] mag;
    } sum_t;

endpackage

// File: rtl/fpu_addsub_lzc12.sv
// Leading-zero count of a 12-bit value; an all-zero input reports 12.
// Shared by the add/sub, itof and mulf normalizers.
module lzc12 (
    input  logic [11:0] value,
    output logic [3:0]  count
);

    // Ascending scan so the most significant set bit is the one that sticks.
    always_comb begin
        count = 4'd12;
        for (int i = 0; i < 12; i++) begin
            if (value[i]) count = 4'(11 - i);
        end
    end

endmodule

// File: rtl/fpu_addsub.sv
// Three-stage float add/subtract: S1 align, S2 add, S3 normalize/pack.
// Valid/ready: a transfer happens on a rising edge where valid && ready; one global stall.
module fpu_addsub
    import fpu_addsub_pkg::*;
#(
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sub,
    input  logic [15:0]     in_a,
    input  logic [15:0]     in_b,
    input  logic [TAGW-1:0] in_dest,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_result,
    output logic [TAGW-1:0] out_dest,
    output logic            out_zero,
    output logic            busy
);

    logic            advance;
    logic            s1_valid, s2_valid;
    align_t          s1_q, s1_d;
    sum_t            s2_q, s2_d;
    logic [TAGW-1:0] s1_dest, s2_dest;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;
    assign busy     = s1_valid || s2_valid || out_valid;

    // ---------------- S1: align ----------------
    logic             b_sign, swap;
    logic [14:0]      key_a, key_b, mag_l, mag_s;
    logic [EXP_W-1:0] exp_l, exp_s, exp_diff;
    logic [MAN_W-1:0] man_s8;

    assign b_sign = in_b[SIGN_BIT] ^ in_sub;
    assign key_a  = (in_a[EXP_MSB:EXP_LSB] == '0) ? 15'd0 : in_a[EXP_MSB:0];
    assign key_b  = (in_b[EXP_MSB:EXP_LSB] == '0) ? 15'd0 : in_b[EXP_MSB:0];
    assign swap   = key_b > key_a;
    assign mag_l  = swap ? key_b : key_a;
    assign mag_s  = swap ? key_a : key_b;
    assign exp_l  = mag_l[EXP_MSB:EXP_LSB];
    assign exp_s  = mag_s[EXP_MSB:EXP_LSB];
    assign exp_diff = exp_l - exp_s;
    assign man_s8 = fp_mant(mag_s);

    always_comb begin
        s1_d.sign_l = swap ? b_sign : in_a[SIGN_BIT];
        s1_d.sign_s = swap ? in_a[SIGN_BIT] : b_sign;
        s1_d.exp    = exp_l;
        s1_d.man_l  = {fp_mant(mag_l), {GRD_W{1'b0}}};
        s1_d.man_s  = (exp_diff >= 8'(ALN_W)) ? '0 : ({man_s8, {GRD_W{1'b0}}} >> exp_diff);
    end

    // ---------------- S2: add / subtract magnitudes ----------------
    always_comb begin
        s2_d.sign = s1_q.sign_l;
        s2_d.exp  = s1_q.exp;
        if (s1_q.sign_l == s1_q.sign_s)
            s2_d.mag = {1'b0, s1_q.man_l} + {1'b0, s1_q.man_s};
        else
            s2_d.mag = {1'b0, s1_q.man_l} - {1'b0, s1_q.man_s};
    end

    // ---------------- S3: normalize / pack ----------------
    logic [3:0]        lz;
    logic [SUM_W-1:0]  norm;
    logic [FRAC_W-1:0] frac_n;
    logic signed [9:0] exp_n;
    logic [15:0]       res_n;

    lzc12 u_lzc (
        .value (s2_q.mag),
        .count (lz)
    );

    // Shifting the leading one up to the carry position covers both the
    // carry case (lz = 0, exponent + 1) and the cancellation case uniformly.
    assign norm   = s2_q.mag << lz;
    assign frac_n = 7'(norm >> (GRD_W + 1));
    assign exp_n  = $signed({2'b00, s2_q.exp}) + 10'sd1 - $signed({6'd0, lz});

    always_comb begin
        res_n = {s2_q.sign, 8'(exp_n), frac_n};
        if (s2_q.mag == '0 || exp_n < 10'sd1)
            res_n = 16'h0000;
        else if (exp_n > $signed({2'b00, EXP_MAX}))
            res_n = {s2_q.sign, SAT_MAG};
    end

    // ---------------- stage registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= 16'h0000;
            out_dest   <= '0;
            out_zero   <= 1'b1;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_result <= res_n;
                out_dest   <= s2_dest;
                out_zero   <= (res_n == 16'h0000);
            end
        end
    end

    // Payload registers only need to follow their valid bits.
    always_ff @(posedge clk) begin
        if (advance) begin
            if (in_valid) begin
                s1_q    <= s1_d;
                s1_dest <= in_dest;
            end
            if (s1_valid) begin
                s2_q    <= s2_d;
                s2_dest <= s1_dest;
            end
        end
    end

endmodule

// File: tb/tb_fpu_addsub.sv
// Bench for fpu_addsub: directed literal cases, backpressure, reset and random
// traffic, all scored against a value-level float model on every output handshake.
module tb_fpu_addsub;

    localparam int TAGW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_sub = 1'b0;
    logic [15:0]     in_a = '0;
    logic [15:0]     in_b = '0;
    logic [TAGW-1:0] in_dest = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [15:0]     out_result;
    logic [TAGW-1:0] out_dest;
    logic            out_zero;
    logic            busy;

    logic [TAGW+15:0] exp_q[$];
    logic [TAGW+15:0] e_item;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_mode = 0;
    int bp_base = 0;
    int out_cnt = 0;
    int stall_cnt = 0;

    fpu_addsub #(.TAGW(TAGW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
        .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest), .out_zero(out_zero),
        .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Consumer side: always ready, random, or a fixed stall window.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !((cyc - bp_base) >= 4 && (cyc - bp_base) <= 7);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int ea, eb, ma, mb, ka, kb, d, mag, e, t;
        logic sa, sb, ts;
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        ka = (ea == 0) ? 0 : int'(a[14:0]);
        kb = (eb == 0) ? 0 : int'(b[14:0]);
        ma = (ea == 0) ? 0 : 128 + int'(a[6:0]);
        mb = (eb == 0) ? 0 : 128 + int'(b[6:0]);
        sa = a[15];
        sb = b[15] ^ sub;
        if (kb > ka) begin
            t = ea; ea = eb; eb = t;
            t = ma; ma = mb; mb = t;
            ts = sa; sa = sb; sb = ts;
        end
        d  = ea - eb;
        ma = ma * 8;
        mb = (d >= 11) ? 0 : (mb * 8) >> d;
        mag = (sa == sb) ? ma + mb : ma - mb;
        e = ea;
        if (mag == 0) return 16'h0000;
        while (mag >= 2048) begin mag = mag / 2; e++; end
        while (mag < 1024) begin mag = mag * 2; e--; end
        if (e < 1) return 16'h0000;
        if (e > 254) return {sa, 15'h7F7F};
        return {sa, e[7:0], mag[9:3]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic [TAGW-1:0] dest, input logic [15:0] expv);
        int waited = 0;
        logic rdy;
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_dest = dest;
        do begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            waited++;
        end while (!rdy && waited < 50);
        if (!rdy) begin
            total++; bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            exp_q.push_back({dest, expv});
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin idle(1); n++; end
        check("drain_empty", exp_q.size(), 0);
        idle(3);
    endtask

    // ---------------- scoreboard / compare ----------------
    logic [15:0]     prev_res;
    logic [TAGW-1:0] prev_dest;
    logic            prev_zero;
    logic            prev_stall = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_result", out_result, prev_res);
                check("stall_dest", out_dest, prev_dest);
                check("stall_zero", out_zero, prev_zero);
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got %h expected none", out_result);
                end else begin
                    e_item = exp_q.pop_front();
                    check("result", out_result, e_item[15:0]);
                    check("dest", out_dest, e_item[TAGW+15:16]);
                    check("zero", out_zero, e_item[15:0] == 16'h0000);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_dest  = out_dest;
            prev_zero  = out_zero;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- directed cases (hand-computed) ----------------
    logic [15:0] dir_a [12] = '{16'h3F80, 16'h3FC0, 16'h3F80, 16'h3F80, 16'h0000, 16'h7F7F,
                                16'hFF7F, 16'h0080, 16'h4040, 16'h3F80, 16'h007F, 16'h3F80};
    logic [15:0] dir_b [12] = '{16'h3F80, 16'h3FC0, 16'h4040, 16'h3400, 16'hC0A0, 16'h7F7F,
                                16'hFF7F, 16'h00C0, 16'h3F80, 16'h3F00, 16'h3F80, 16'h3C01};
    logic        dir_s [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] dir_r [12] = '{16'h4000, 16'h0000, 16'hC000, 16'h3F80, 16'hC0A0, 16'h7F7F,
                                16'hFF7F, 16'h0000, 16'h4080, 16'h3F00, 16'h3F80, 16'h3F81};

    logic [15:0] ra, rb;
    logic [7:0]  re;
    logic        rs;
    int lat, cnt_before;

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", out_result, 16'h0000);
        check("rst_dest", out_dest, 0);
        check("rst_zero", out_zero, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        @(posedge clk); #1;

        // Single add with exact latency.
        check("model_add", model(16'h3F80, 16'h3F80, 1'b0), 16'h4000);
        send_op(16'h3F80, 16'h3F80, 1'b0, 4'h1, 16'h4000);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 10);
        check("latency", lat, 3);
        check("lat_result", out_result, 16'h4000);
        check("lat_zero", out_zero, 0);
        @(posedge clk); #1;
        drain();

        // Directed table, back-to-back.
        for (int i = 0; i < 12; i++) begin
            check($sformatf("model_%0d", i), model(dir_a[i], dir_b[i], dir_s[i]), dir_r[i]);
            send_op(dir_a[i], dir_b[i], dir_s[i], 4'(i), dir_r[i]);
        end
        drain();

        // Backpressure: five ops streaming into a 4-cycle stall window.
        stall_cnt = 0;
        cnt_before = out_cnt;
        bp_base = cyc + 1;
        ready_mode = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            send_op(ra, rb, rs, 4'(i + 3), model(ra, rb, rs));
        end
        drain();
        ready_mode = 0;
        check("bp_stalled", stall_cnt >= 4, 1);
        check("bp_count", out_cnt - cnt_before, 5);

        // Reset with three operations in flight.
        idle(2);
        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            send_op(ra, rb, 1'b0, 4'(i + 9), model(ra, rb, 1'b0));
        end
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_zero", out_zero, 1);
        exp_q.delete();
        cnt_before = out_cnt;
        @(posedge clk); #1;
        reset = 1'b1;
        idle(8);
        check("no_stale_out", out_cnt - cnt_before, 0);
        check("idle_busy", busy, 0);

        // Random traffic with random backpressure.
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            ra = 16'($urandom);
            rs = 1'($urandom);
            case ($urandom_range(0, 4))
                0: rb = 16'($urandom);
                1: begin
                    re = ra[14:7] + 8'($urandom_range(0, 3));
                    rb = {1'($urandom), re, 7'($urandom)};
                end
                2: rb = {1'($urandom), ra[14:0]};
                3: begin
                    ra[14:7] = 8'($urandom_range(248, 255));
                    rb = {1'($urandom), 8'($urandom_range(248, 255)), 7'($urandom)};
                end
                default: begin
                    ra[14:7] = 8'($urandom_range(0, 2));
                    rb = {1'($urandom), 8'($urandom_range(0, 3)), 7'($urandom)};
                end
            endcase
            send_op(ra, rb, rs, 4'($urandom), model(ra, rb, rs));
        end
        ready_mode = 0;
        idle(2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
